// File: rtl/mult_div.sv
// Sequential signed 32x32 multiplier (radix-2 Booth) and restoring divider.
// HI/LO update only on completion; done/div_zero are single-cycle registered pulses.
module mult_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        mult_start,
  input  logic        div_start,
  input  logic [31:0] regA_out,
  input  logic [31:0] regB_out,
  output logic [31:0] HI_out,
  output logic [31:0] LO_out,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W:0]       acc_q, acc_d;      // Booth upper half / division remainder
  logic [W-1:0]     shr_q, shr_d;      // Booth multiplier / dividend-then-quotient
  logic             q1_q, q1_d;        // Booth Q(-1) bit
  logic [W:0]       mcand_q, mcand_d;  // sign-extended multiplicand or divisor magnitude
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  logic [W:0]       sum, shifted, rem_n;
  logic             ge;
  logic [W-1:0]     a_mag, b_mag;

  // Next-state, datapath step and output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    shr_d   = shr_q;
    q1_d    = q1_q;
    mcand_d = mcand_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    sum     = acc_q;
    shifted = {acc_q[W-1:0], shr_q[W-1]};
    ge      = 1'b0;
    rem_n   = shifted;
    a_mag   = regA_out[W-1] ? W'(32'd0 - regA_out) : regA_out;
    b_mag   = regB_out[W-1] ? W'(32'd0 - regB_out) : regB_out;

    unique case (state_q)
      IDLE: begin
        if (mult_start) begin
          mcand_d = {regA_out[W-1], regA_out};
          acc_d   = '0;
          shr_d   = regB_out;
          q1_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = MULT;
        end else if (div_start) begin
          mcand_d = {1'b0, b_mag};
          acc_d   = '0;
          shr_d   = a_mag;
          neg_q_d = regA_out[W-1] ^ regB_out[W-1];
          neg_r_d = regA_out[W-1];
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = DIV;
        end
      end
      MULT: begin
        unique case ({shr_q[0], q1_q})
          2'b01:   sum = acc_q + mcand_q;
          2'b10:   sum = acc_q - mcand_q;
          default: sum = acc_q;
        endcase
        acc_d = {sum[W], sum[W:1]};
        shr_d = {sum[0], shr_q[W-1:1]};
        q1_d  = shr_q[0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W - 1)) begin
          hi_d    = acc_d[W-1:0];
          lo_d    = shr_d;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      DIV: begin
        if (mcand_q[W-1:0] == '0) begin
          dz_d    = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          ge    = (shifted >= mcand_q);
          rem_n = ge ? (shifted - mcand_q) : shifted;
          acc_d = rem_n;
          shr_d = {shr_q[W-2:0], ge};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(W - 1)) begin
            lo_d    = neg_q_q ? W'(32'd0 - shr_d) : shr_d;
            hi_d    = neg_r_q ? W'(32'd0 - acc_d[W-1:0]) : acc_d[W-1:0];
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      shr_q   <= '0;
      q1_q    <= 1'b0;
      mcand_q <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      shr_q   <= shr_d;
      q1_q    <= q1_d;
      mcand_q <= mcand_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign HI_out   = hi_q;
  assign LO_out   = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div.sv
// Randomized self-checking bench for mult_div against a plain-arithmetic reference.
module tb_mult_div;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mult_start = 1'b0;
  logic        div_start = 1'b0;
  logic [31:0] regA_out = '0;
  logic [31:0] regB_out = '0;
  logic [31:0] HI_out, LO_out;
  logic        busy, done, div_zero;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mult_div dut (
    .clk        (clk),
    .reset      (reset),
    .mult_start (mult_start),
    .div_start  (div_start),
    .regA_out   (regA_out),
    .regB_out   (regB_out),
    .HI_out     (HI_out),
    .LO_out     (LO_out),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One operation with cycle-exact checks; expected results from signed 64-bit arithmetic.
  task automatic run_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                        input bit both, input bit poke);
    longint      sa, sb, p, q, r;
    bit          dz;
    int          lat;
    logic [31:0] eh, el;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    if (is_mult) begin
      p  = sa * sb;
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 32'd0) begin
      dz = 1'b1;
      eh = m_hi;
      el = m_lo;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      el = q[31:0];
      eh = r[31:0];
    end
    lat = dz ? 1 : 32;

    @(negedge clk);
    mult_start = is_mult | both;
    div_start  = ~is_mult | both;
    regA_out   = a;
    regB_out   = b;
    @(posedge clk);
    #1;
    mult_start = 1'b0;
    div_start  = 1'b0;
    regA_out   = $urandom;
    regB_out   = $urandom;
    check("busy_start", 64'(busy), 64'(1));
    for (int n = 1; n < lat; n++) begin
      mult_start = poke && (n == 5);
      div_start  = poke && (n == 5);
      @(posedge clk);
      #1;
      mult_start = 1'b0;
      div_start  = 1'b0;
      check("mid_ctl", 64'({busy, done, div_zero}), 64'(3'b100));
      check("mid_hold", {HI_out, LO_out}, {m_hi, m_lo});
    end
    @(posedge clk);
    #1;
    check("done_ctl", 64'({busy, done, div_zero}), 64'({1'b0, 1'b1, dz}));
    check("result", {HI_out, LO_out}, {eh, el});
    m_hi = eh;
    m_lo = el;
    @(posedge clk);
    #1;
    check("post_ctl", 64'({busy, done, div_zero}), 64'(3'b000));
    check("post_hold", {HI_out, LO_out}, {m_hi, m_lo});
  endtask

  initial begin
    logic [31:0] a, b;
    bit          op;
    int          sel;

    #2 reset = 1'b0;
    #1;
    check("reset_data", {HI_out, LO_out}, 64'd0);
    check("reset_ctl", 64'({busy, done, div_zero}), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    run_op(1'b1, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    run_op(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(1'b0, 32'h5678_1234, 32'h0001_0000, 1'b0, 1'b0);
    check("preset_hilo", {HI_out, LO_out}, {32'h0000_1234, 32'h0000_5678});
    run_op(1'b0, 32'd5, 32'd0, 1'b0, 1'b0);
    run_op(1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b1);
    run_op(1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFF0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a multiply
    @(negedge clk);
    mult_start = 1'b1;
    regA_out   = 32'h1234_5678;
    regB_out   = 32'h9ABC_DEF0;
    @(posedge clk);
    #1;
    mult_start = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("rst_async_data", {HI_out, LO_out}, 64'd0);
    check("rst_async_ctl", 64'({busy, done, div_zero}), 64'(0));
    m_hi = '0;
    m_lo = '0;
    @(posedge clk);
    #2 reset = 1'b1;
    run_op(1'b1, 32'hFFFF_FF00, 32'd300, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      op  = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      sel = int'($urandom_range(0, 7));
      if (sel == 0) b = 32'd0;
      if (sel == 1) b = 32'($urandom_range(1, 3));
      if (sel == 2) a = 32'h8000_0000;
      if (sel == 3) b = 32'hFFFF_FFFF;
      run_op(op, a, b, 1'b0, (sel == 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
